// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the RAM-port initiator: default widths,
// FSM state encoding and a burst-length helper.
package mem_access_ctrl_pkg;

   localparam int MAC_ADDR_W = 9;
   localparam int MAC_DATA_W = 32;
   localparam int MAC_LEN_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_DRAIN,
      S_RD,
      S_RD_DRAIN,
      S_DONE
   } state_t;

   function automatic int unsigned burst_words(input int unsigned len);
      return len + 1;
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator side of the on-chip RAM port: turns load/store burst requests
// into registered RAM read/write cycles and returns read data one word per cycle.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = MAC_ADDR_W,
   parameter int DATA_W = MAC_DATA_W,
   parameter int LEN_W  = MAC_LEN_W
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   output logic              rdata_last,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cur,  w_cur_nxt;
   logic [LEN_W-1:0]    r_cnt,  w_cnt_nxt;
   logic [LEN_W-1:0]    r_len,  w_len_nxt;
   logic                r_ram_read,  w_read_nxt;
   logic                r_ram_write, w_write_nxt;
   logic [ADDR_W-1:0]   r_ram_address, w_addr_nxt;
   logic [DATA_W-1:0]   r_ram_data_in, w_din_nxt;
   logic                r_rdata_valid;
   logic                r_rdata_last;
   logic                r_done;

   always_ff @(posedge clock) begin
      if (clear) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // r_cnt is the index of the beat currently being presented to the RAM
   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_read_nxt  = 1'b0;
      w_write_nxt = 1'b0;
      w_addr_nxt  = r_ram_address;
      w_din_nxt   = r_ram_data_in;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_len_nxt = req_len;
               w_cnt_nxt = '0;
               if (req_write) begin
                  w_state_nxt = S_WR;
                  w_cur_nxt   = req_addr;
               end else begin
                  w_state_nxt = S_RD;
                  w_read_nxt  = 1'b1;
                  w_addr_nxt  = req_addr;
                  w_cur_nxt   = req_addr + 1'b1;
               end
            end
         end
         S_WR: begin
            if (wdata_valid) begin
               w_write_nxt = 1'b1;
               w_addr_nxt  = r_cur;
               w_din_nxt   = wdata;
               w_cur_nxt   = r_cur + 1'b1;
               w_cnt_nxt   = r_cnt + 1'b1;
               if (r_cnt == r_len) w_state_nxt = S_WR_DRAIN;
            end
         end
         S_RD: begin
            if (r_cnt == r_len) begin
               w_state_nxt = S_RD_DRAIN;
            end else begin
               w_read_nxt = 1'b1;
               w_addr_nxt = r_cur;
               w_cur_nxt  = r_cur + 1'b1;
               w_cnt_nxt  = r_cnt + 1'b1;
            end
         end
         S_WR_DRAIN, S_RD_DRAIN: w_state_nxt = S_DONE;
         S_DONE:                 w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_cur         <= '0;
         r_cnt         <= '0;
         r_len         <= '0;
         r_ram_read    <= 1'b0;
         r_ram_write   <= 1'b0;
         r_ram_address <= '0;
         r_ram_data_in <= '0;
         r_rdata_valid <= 1'b0;
         r_rdata_last  <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_cur         <= w_cur_nxt;
         r_cnt         <= w_cnt_nxt;
         r_len         <= w_len_nxt;
         r_ram_read    <= w_read_nxt;
         r_ram_write   <= w_write_nxt;
         r_ram_address <= w_addr_nxt;
         r_ram_data_in <= w_din_nxt;
         r_rdata_valid <= r_ram_read;
         r_rdata_last  <= r_ram_read && (r_state == S_RD) && (r_cnt == r_len);
         r_done        <= (w_state_nxt == S_DONE);
      end
   end

   assign req_ready   = (r_state == S_IDLE);
   assign wdata_ready = (r_state == S_WR);
   assign ram_read    = r_ram_read;
   assign ram_write   = r_ram_write;
   assign ram_address = r_ram_address;
   assign ram_data_in = r_ram_data_in;
   assign rdata_valid = r_rdata_valid;
   assign rdata_last  = r_rdata_last;
   assign rdata       = ram_data_out;
   assign done        = r_done;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a 512x32 write-priority RAM model;
// the reference is a shadow memory plus cycle arithmetic derived from burst rules.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int DEPTH = 512;

   logic          clock = 1'b0;
   logic          clear;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic          wdata_valid, wdata_ready;
   logic [DW-1:0] wdata;
   logic          rdata_valid, rdata_last;
   logic [DW-1:0] rdata;
   logic          done;
   logic          ram_read, ram_write;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out;

   always #5 clock = ~clock;

   mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clock(clock), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata_last(rdata_last), .rdata(rdata),
      .done(done),
      .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   logic [DW-1:0] mem [DEPTH];
   always @(posedge clock) begin
      if (ram_write)     mem[ram_address] <= ram_data_in;
      else if (ram_read) ram_data_out     <= mem[ram_address];
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            chk_data;
      bit            last;
      int            cyc;
   } exp_t;

   exp_t q_wr[$];
   exp_t q_ra[$];
   exp_t q_rd[$];
   int   q_done[$];

   logic [DW-1:0] ref_mem [DEPTH];
   bit            known   [DEPTH];

   int cyc = 0;
   int n_pass = 0;
   int n_tot  = 0;
   int last_acc = 0;
   int last_done_exp = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
   endtask

   task automatic fail_evt(input string nm);
      n_tot++;
      $display("FAIL %s: got activity at cycle %0d, required none", nm, cyc);
   endtask

   function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base, input int off);
      return AW'((int'(base) + off) % DEPTH);
   endfunction

   always @(negedge clock) begin : monitor
      exp_t e;
      int   de;
      if (ram_read && ram_write) fail_evt("ram_read_and_write");
      if (ram_write) begin
         if (q_wr.size() == 0) fail_evt("unexpected_ram_write");
         else begin
            e = q_wr.pop_front();
            chk("wr_addr", ram_address, e.addr);
            chk("wr_data", ram_data_in, e.data);
            chk("wr_cycle", cyc, e.cyc);
         end
      end
      if (ram_read) begin
         if (q_ra.size() == 0) fail_evt("unexpected_ram_read");
         else begin
            e = q_ra.pop_front();
            chk("rd_addr", ram_address, e.addr);
            chk("rd_cycle", cyc, e.cyc);
         end
      end
      if (rdata_valid) begin
         if (q_rd.size() == 0) fail_evt("unexpected_rdata_valid");
         else begin
            e = q_rd.pop_front();
            if (e.chk_data) chk("rdata", rdata, e.data);
            chk("rdata_last", rdata_last, e.last);
            chk("rdata_cycle", cyc, e.cyc);
         end
      end
      if (done) begin
         if (q_done.size() == 0) fail_evt("unexpected_done");
         else begin
            de = q_done.pop_front();
            chk("done_cycle", cyc, de);
         end
      end
   end

   // Called at a negedge with req_valid high; returns the accept edge number.
   task automatic wait_accept(output int acc);
      int k = 0;
      while (!req_ready && k < 200) begin
         @(negedge clock);
         k++;
      end
      if (!req_ready) begin
         $display("FAIL req_ready_timeout: got 0 after %0d cycles, required 1", k);
         $fatal(1, "request never accepted");
      end
      acc = cyc + 1;
      @(negedge clock);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
      req_len   = LW'($urandom);
   endtask

   task automatic do_load(input logic [AW-1:0] a, input int len);
      int acc;
      req_write = 1'b0;
      req_addr  = a;
      req_len   = LW'(len);
      req_valid = 1'b1;
      wait_accept(acc);
      for (int i = 0; i < int'(burst_words(len)); i++) begin
         exp_t e;
         e.addr     = wrap_addr(a, i);
         e.data     = ref_mem[e.addr];
         e.chk_data = known[e.addr];
         e.last     = (i == len);
         e.cyc      = acc + i;
         q_ra.push_back(e);
         e.cyc      = acc + 1 + i;
         q_rd.push_back(e);
      end
      q_done.push_back(acc + 2 + len);
      last_acc      = acc;
      last_done_exp = acc + 2 + len;
   endtask

   // pat/plen give the wdata_valid pattern per slot; beyond plen slots are random.
   task automatic do_store(input logic [AW-1:0] a, input int len, input logic [31:0] pat,
                           input int plen, input bit fixed, input logic [DW-1:0] fdata,
                           input int abort_at);
      int acc;
      int slot = 0;
      int beat = 0;
      int last_h = 0;
      req_write = 1'b1;
      req_addr  = a;
      req_len   = LW'(len);
      req_valid = 1'b1;
      wait_accept(acc);
      last_acc = acc;
      while (beat <= len) begin
         bit v;
         v = (slot < plen) ? pat[slot] : ($urandom_range(0, 99) < 75);
         slot++;
         if (v) begin
            exp_t e;
            wdata_valid = 1'b1;
            wdata       = fixed ? (fdata + DW'(beat)) : DW'($urandom);
            chk("wdata_ready", wdata_ready, 1'b1);
            if (beat == abort_at) begin
               clear = 1'b1;
               @(negedge clock);
               clear       = 1'b0;
               wdata_valid = 1'b0;
               chk("abort_ram_write", ram_write, 1'b0);
               chk("abort_done", done, 1'b0);
               chk("abort_req_ready", req_ready, 1'b1);
               return;
            end
            e.addr     = wrap_addr(a, beat);
            e.data     = wdata;
            e.chk_data = 1'b1;
            e.last     = (beat == len);
            e.cyc      = cyc + 1;
            q_wr.push_back(e);
            ref_mem[e.addr] = wdata;
            known[e.addr]   = 1'b1;
            last_h = cyc + 1;
            beat++;
         end else begin
            wdata_valid = 1'b0;
            wdata       = DW'($urandom);
         end
         @(negedge clock);
      end
      wdata_valid = 1'b0;
      q_done.push_back(last_h + 1);
      last_done_exp = last_h + 1;
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clock);
      while (!req_ready && k < 200) begin
         @(negedge clock);
         k++;
      end
      chk("idle_reached", req_ready, 1'b1);
   endtask

   initial begin
      int d1;
      clear       = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_len     = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

      repeat (3) @(negedge clock);
      clear = 1'b0;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_wdata_ready", wdata_ready, 1'b0);
      chk("rst_ram_read", ram_read, 1'b0);
      chk("rst_ram_write", ram_write, 1'b0);
      chk("rst_ram_address", ram_address, '0);
      chk("rst_ram_data_in", ram_data_in, '0);
      chk("rst_rdata_valid", rdata_valid, 1'b0);
      chk("rst_done", done, 1'b0);

      // clear and a request on the same edge: clear wins
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = AW'(16'h055);
      clear     = 1'b1;
      @(negedge clock);
      clear     = 1'b0;
      req_valid = 1'b0;
      chk("clr_req_not_accepted", ram_read, 1'b0);
      chk("clr_req_ready", req_ready, 1'b1);
      repeat (3) @(negedge clock);

      do_store(AW'(16'h010), 0, 32'h1, 1, 1'b1, 32'hDEADBEEF, -1);
      wait_idle();
      do_load(AW'(16'h010), 0);
      wait_idle();

      do_store(AW'(16'h020), 3, '1, 32, 1'b0, '0, -1);
      wait_idle();
      do_load(AW'(16'h020), 3);
      wait_idle();

      do_store(AW'(16'h030), 3, 32'b101101, 6, 1'b0, '0, -1);
      wait_idle();
      do_load(AW'(16'h030), 3);
      wait_idle();

      do_store(AW'(16'h1FE), 3, '1, 32, 1'b0, '0, -1);
      wait_idle();
      do_load(AW'(16'h1FE), 3);
      wait_idle();

      do_store(AW'(16'h100), 7, '1, 32, 1'b0, '0, -1);
      wait_idle();
      do_store(AW'(16'h100), 7, '1, 32, 1'b1, 32'hA5A50000, 2);
      repeat (3) @(negedge clock);
      do_load(AW'(16'h100), 7);
      wait_idle();

      // second request raised while the first burst is still running
      do_load(AW'(16'h020), 3);
      d1 = last_done_exp;
      do_load(AW'(16'h030), 3);
      chk("b2b_accept_cycle", last_acc, d1 + 2);
      wait_idle();

      for (int n = 0; n < 25; n++) begin
         logic [AW-1:0] a;
         int            len;
         a   = AW'($urandom_range(0, DEPTH - 1));
         len = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) do_store(a, len, '0, 0, 1'b0, '0, -1);
         else                           do_load(a, len);
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();
      repeat (5) @(negedge clock);

      chk("q_wr_drained", q_wr.size(), 0);
      chk("q_ra_drained", q_ra.size(), 0);
      chk("q_rd_drained", q_rd.size(), 0);
      chk("q_done_drained", q_done.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
